// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path and its key decoder.
package ps2_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int FRAME_DATA_BITS = 8;

  // 1 ms at 50 MHz between falling edges inside a frame.
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  // Scan-code prefixes interpreted by the key-decode logic.
  localparam logic [7:0] BREAK_CODE    = 8'hF0;
  localparam logic [7:0] EXTENDED_CODE = 8'hE0;

endpackage

// File: rtl/ps2_sync.sv
// Brings the asynchronous PS/2 clock and data lines into the CLOCK_50 domain
// and flags falling edges of the synchronised PS/2 clock.
module ps2_sync
  import ps2_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clk_pad,
  input  logic dat_pad,
  output logic clk_fall,
  output logic dat_sync
);

  logic clk_p0;
  logic clk_p1;
  logic clk_p2;
  logic dat_p0;
  logic dat_p1;

  // Two-flop synchronisers plus one history flop on the clock line; all
  // reset to the idle (released, pulled-up) line level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= clk_pad;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= dat_pad;
      dat_p1 <= dat_p0;
    end
  end

  // Synchronised level: previous sample high, current sample low.
  assign clk_fall = clk_p2 & ~clk_p1;
  assign dat_sync = dat_p1;

endmodule

// File: rtl/ps2_controller.sv
// Receive-only PS/2 host: deserialises 11-bit device-to-host frames and
// presents each good byte with a one-cycle strobe.
module ps2_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  ps2_state_t                       state;
  logic [FRAME_DATA_BITS-1:0]       shift_reg;
  logic [2:0]                       bit_cnt;
  logic                             parity_bit;
  logic [15:0]                      idle_cnt;
  logic                             ps2_fall;
  logic                             ps2_dat;
  logic                             timed_out;

  // Odd parity over data plus parity bit, and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return stop & (^{data, parity});
  endfunction

  // The pads are only ever observed; the host never pulls them low.
  ps2_sync u_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clk_pad  (PS2_CLK),
    .dat_pad  (PS2_DAT),
    .clk_fall (ps2_fall),
    .dat_sync (ps2_dat)
  );

  // A same-cycle falling edge takes priority over expiry.
  assign timed_out = (idle_cnt >= TIMEOUT_LIMIT) && !ps2_fall;

  // Frame FSM, shift register, stall counter and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= IDLE;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      parity_bit       <= 1'b0;
      idle_cnt         <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
    end else begin
      received_data_en <= 1'b0;

      if (state == IDLE || ps2_fall || timed_out) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (ps2_fall && !ps2_dat) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (ps2_fall) begin
            shift_reg <= {ps2_dat, shift_reg[FRAME_DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        PARITY: begin
          if (ps2_fall) begin
            parity_bit <= ps2_dat;
            state      <= STOP;
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        STOP: begin
          if (ps2_fall) begin
            if (frame_ok(shift_reg, parity_bit, ps2_dat)) begin
              received_data    <= shift_reg;
              received_data_en <= 1'b1;
            end
            state <= IDLE;
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_controller.sv
// Scoreboard bench for ps2_controller: expected bytes are queued as frames
// are sent, and a monitor pops and compares on every strobe.
module tb_ps2_controller;

  localparam int TB_TIMEOUT = 5000;
  localparam int SLOW_HALF  = 2000;  // 12.5 kHz PS/2 clock
  localparam int FAST_HALF  = 50;

  logic       CLOCK_50;
  logic       reset;
  logic       clk_drv;
  logic       dat_drv;
  wire        ps2_clk_w;
  wire        ps2_dat_w;
  logic [7:0] received_data;
  logic       received_data_en;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_q[$];
  logic       prev_en;

  assign ps2_clk_w = clk_drv;
  assign ps2_dat_w = dat_drv;

  ps2_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .PS2_CLK          (ps2_clk_w),
    .PS2_DAT          (ps2_dat_w),
    .received_data    (received_data),
    .received_data_en (received_data_en)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Device-style frame: data changes while clock is high, read on falling edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int half, input int nbits);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dat_drv = f[i];
      wait_cycles(half);
      clk_drv = 1'b0;
      wait_cycles(half);
      clk_drv = 1'b1;
    end
    dat_drv = 1'b1;
  endtask

  // Monitor: every strobe must match the oldest expected byte and last one cycle.
  always @(negedge CLOCK_50) begin
    if (received_data_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got data %h, expected no strobe", received_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (received_data !== e) begin
          miscompares++;
          $display("FAIL strobe_data: got %h, expected %h", received_data, e);
        end
      end
      if (prev_en === 1'b1) begin
        miscompares++;
        $display("FAIL strobe_width: got strobe high 2+ cycles, expected 1");
      end
    end
    prev_en <= received_data_en;
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clk_drv     = 1'b1;
    dat_drv     = 1'b1;
    wait_cycles(5);
    check8("reset_data", received_data, 8'h00);
    check8("reset_en", {7'd0, received_data_en}, 8'h00);
    reset = 1'b0;
    wait_cycles(5);

    // Make code 0x16 at the real 12.5 kHz rate.
    exp_q.push_back(8'h16);
    send_frame(8'h16, 1'b0, 1'b1, SLOW_HALF, 11);
    wait_cycles(20);
    check8("make_16_hold", received_data, 8'h16);

    // Break sequence, back-to-back with minimal gap.
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h16);
    send_frame(8'hF0, 1'b1, 1'b1, FAST_HALF, 11);
    send_frame(8'h16, 1'b0, 1'b1, FAST_HALF, 11);
    wait_cycles(20);
    check8("break_seq_last", received_data, 8'h16);

    // Parity error: rejected, data retained.
    send_frame(8'h16, 1'b1, 1'b1, FAST_HALF, 11);
    wait_cycles(20);
    check8("parity_err_hold", received_data, 8'h16);

    // Bad stop bit, then the same byte framed correctly.
    send_frame(8'h1E, 1'b1, 1'b0, FAST_HALF, 11);
    wait_cycles(20);
    check8("bad_stop_hold", received_data, 8'h16);
    exp_q.push_back(8'h1E);
    send_frame(8'h1E, 1'b1, 1'b1, FAST_HALF, 11);
    wait_cycles(20);
    check8("good_1e", received_data, 8'h1E);

    // Partial frame abandoned by timeout, then a full frame.
    send_frame(8'h26, 1'b0, 1'b1, FAST_HALF, 5);
    wait_cycles(TB_TIMEOUT + 1000);
    check8("timeout_hold", received_data, 8'h1E);
    exp_q.push_back(8'h26);
    send_frame(8'h26, 1'b0, 1'b1, FAST_HALF, 11);
    wait_cycles(20);
    check8("after_timeout_26", received_data, 8'h26);

    // Reset after D3, then a fresh frame.
    send_frame(8'h25, 1'b0, 1'b1, FAST_HALF, 5);
    wait_cycles(FAST_HALF);
    reset = 1'b1;
    wait_cycles(3);
    check8("midreset_data", received_data, 8'h00);
    check8("midreset_en", {7'd0, received_data_en}, 8'h00);
    reset = 1'b0;
    wait_cycles(10);
    check8("post_reset_data", received_data, 8'h00);
    exp_q.push_back(8'h25);
    send_frame(8'h25, 1'b0, 1'b1, FAST_HALF, 11);
    wait_cycles(20);
    check8("after_reset_25", received_data, 8'h25);
    check8("strobe_idle_end", {7'd0, received_data_en}, 8'h00);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
